// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT PE sequencer slice.
// - state_t : sequencer FSM encoding
// - STAGE_W : width of the stage counter (covers LOG_LEN up to 12, plus one past the end)
// - len_of  : LEN = 1 << LOG_LEN
// Twiddle ROM address layout is {inv, k}: inv selects the inverse-twiddle half.
package ntt_pkg;

  localparam int unsigned STAGE_W     = 4;
  localparam int unsigned LOG_LEN_MAX = 12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_CAP_B = 3'd3,
    S_EV0   = 3'd4,
    S_EV1   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  function automatic int unsigned len_of(input int unsigned log_len);
    return 32'd1 << log_len;
  endfunction

endpackage

// File: rtl/ntt_pe_sequencer_if.sv
// Bus bundle between the sequencer and its RAM / twiddle ROM / PE cell.
// master: sequencer side (drives addresses, write strobe, PE operands).
// slave : memory/PE side (returns read data, twiddle data, PE result).
interface ntt_pe_sequencer_if #(
  parameter int unsigned N       = 17,
  parameter int unsigned LOG_LEN = 4
);
  logic [LOG_LEN-1:0] mem_rd_addr;
  logic [N-1:0]       mem_rd_data;
  logic               mem_wr_en;
  logic [LOG_LEN-1:0] mem_wr_addr;
  logic [N-1:0]       mem_wr_data;
  logic [LOG_LEN:0]   tf_addr;
  logic [N-1:0]       tf_data;
  logic [N-1:0]       pe_a;
  logic [N-1:0]       pe_b;
  logic [N-1:0]       pe_tf;
  logic               pe_sub;
  logic               pe_inv;
  logic [N-1:0]       pe_p;

  modport master (
    output mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, tf_addr,
           pe_a, pe_b, pe_tf, pe_sub, pe_inv,
    input  mem_rd_data, tf_data, pe_p
  );

  modport slave (
    input  mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, tf_addr,
           pe_a, pe_b, pe_tf, pe_sub, pe_inv,
    output mem_rd_data, tf_data, pe_p
  );
endinterface

// File: rtl/ntt_addr_gen.sv
// Butterfly address generator: (stage s, butterfly j, inv) -> (ia, ib, twiddle k, last flags).
// Ports: s, j, inv in; ia_c, ib_c, k_c, last_j_c, last_s_c out (all combinational).
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int unsigned LOG_LEN = 4
) (
  input  logic [STAGE_W-1:0] s,
  input  logic [LOG_LEN-1:0] j,
  input  logic               inv,
  output logic [LOG_LEN-1:0] ia_c,
  output logic [LOG_LEN-1:0] ib_c,
  output logic [LOG_LEN-1:0] k_c,
  output logic               last_j_c,
  output logic               last_s_c
);

  localparam int unsigned LEN  = len_of(LOG_LEN);
  localparam int unsigned HALF = LEN / 2;

  logic [STAGE_W-1:0] l;     // log2(span)
  logic [LOG_LEN-1:0] span;
  logic [LOG_LEN-1:0] grp;   // butterfly group index j >> L

  // NTT walks spans downward (decimation in time order), INTT upward.
  always_comb begin
    l        = inv ? s : (STAGE_W'(LOG_LEN - 1) - s);
    span     = LOG_LEN'(1) << l;
    grp      = j >> l;
    ia_c     = (grp << (l + STAGE_W'(1))) | (j & (span - LOG_LEN'(1)));
    ib_c     = ia_c + span;
    k_c      = (LOG_LEN'(HALF) >> l) + grp;  // LEN/(2*span) + group
    last_j_c = (j == LOG_LEN'(HALF - 1));
    last_s_c = (s == STAGE_W'(LOG_LEN - 1));
  end

endmodule

// File: rtl/ntt_pe_sequencer.sv
// Sequences one combinational PE cell through an in-place LEN-point NTT/INTT.
// Ports: clk, rst_n (async active-low), start, inv (latched at start),
//        busy, done (one-cycle pulse), bus (master side: RAM/ROM addresses,
//        RAM write port, registered PE operands/mode bits, PE result in).
// Per butterfly: RD_A (ia,tf issued) -> RD_B (ib issued, ia data arrives)
// -> CAP_B (ib data arrives) -> EV0 (sub=0, write ia) -> EV1 (sub=1, write ib).
module ntt_pe_sequencer
  import ntt_pkg::*;
#(
  parameter int unsigned N       = 17,
  parameter int unsigned LOG_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               inv,
  output logic               busy,
  output logic               done,
  ntt_pe_sequencer_if.master bus
);

  state_t             state_q, state_d;
  logic [STAGE_W-1:0] s_q, s_d;
  logic [LOG_LEN-1:0] j_q, j_d;
  logic               fin_q, fin_d;
  logic [LOG_LEN-1:0] rd_addr_q, rd_addr_d;
  logic [LOG_LEN:0]   tf_addr_q, tf_addr_d;
  logic               wr_en_q, wr_en_d;
  logic [LOG_LEN-1:0] wr_addr_q, wr_addr_d;
  logic [N-1:0]       pe_a_q, pe_a_d;
  logic [N-1:0]       pe_b_q, pe_b_d;
  logic [N-1:0]       pe_tf_q, pe_tf_d;
  logic               pe_sub_q, pe_sub_d;
  logic               pe_inv_q, pe_inv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [STAGE_W-1:0] gen_s;
  logic [LOG_LEN-1:0] gen_j;
  logic               gen_inv;
  logic [LOG_LEN-1:0] ia_c, ib_c, k_c;
  logic               last_j_c, last_s_c;

  // In IDLE the generator must already point at butterfly (0,0) of the requested mode.
  always_comb begin
    gen_s   = s_q;
    gen_j   = j_q;
    gen_inv = pe_inv_q;
    if (state_q == S_IDLE) begin
      gen_s   = '0;
      gen_j   = '0;
      gen_inv = inv;
    end
  end

  ntt_addr_gen #(.LOG_LEN(LOG_LEN)) u_addr_gen (
    .s        (gen_s),
    .j        (gen_j),
    .inv      (gen_inv),
    .ia_c     (ia_c),
    .ib_c     (ib_c),
    .k_c      (k_c),
    .last_j_c (last_j_c),
    .last_s_c (last_s_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    j_d       = j_q;
    fin_d     = fin_q;
    rd_addr_d = rd_addr_q;
    tf_addr_d = tf_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    pe_a_d    = pe_a_q;
    pe_b_d    = pe_b_q;
    pe_tf_d   = pe_tf_q;
    pe_sub_d  = pe_sub_q;
    pe_inv_d  = pe_inv_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RD_A;
          s_d       = '0;
          j_d       = '0;
          fin_d     = 1'b0;
          pe_inv_d  = inv;
          rd_addr_d = ia_c;
          tf_addr_d = {inv, k_c};
          busy_d    = 1'b1;
        end
      end
      S_RD_A: begin
        state_d   = S_RD_B;
        rd_addr_d = ib_c;
      end
      S_RD_B: begin
        state_d = S_CAP_B;
        pe_a_d  = bus.mem_rd_data;
        pe_tf_d = bus.tf_data;
      end
      S_CAP_B: begin
        state_d   = S_EV0;
        pe_b_d    = bus.mem_rd_data;
        pe_sub_d  = 1'b0;
        wr_en_d   = 1'b1;
        wr_addr_d = ia_c;
      end
      S_EV0: begin
        // Counters advance here so EV1 can issue the next butterfly's reads.
        state_d   = S_EV1;
        pe_sub_d  = 1'b1;
        wr_en_d   = 1'b1;
        wr_addr_d = ib_c;
        fin_d     = last_j_c & last_s_c;
        if (last_j_c) begin
          j_d = '0;
          s_d = s_q + STAGE_W'(1);
        end else begin
          j_d = j_q + LOG_LEN'(1);
        end
      end
      S_EV1: begin
        if (fin_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d   = S_RD_A;
          rd_addr_d = ia_c;
          tf_addr_d = {pe_inv_q, k_c};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      s_q       <= '0;
      j_q       <= '0;
      fin_q     <= 1'b0;
      rd_addr_q <= '0;
      tf_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      pe_a_q    <= '0;
      pe_b_q    <= '0;
      pe_tf_q   <= '0;
      pe_sub_q  <= 1'b0;
      pe_inv_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      j_q       <= j_d;
      fin_q     <= fin_d;
      rd_addr_q <= rd_addr_d;
      tf_addr_q <= tf_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      pe_a_q    <= pe_a_d;
      pe_b_q    <= pe_b_d;
      pe_tf_q   <= pe_tf_d;
      pe_sub_q  <= pe_sub_d;
      pe_inv_q  <= pe_inv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.tf_addr     = tf_addr_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_addr = wr_addr_q;
  assign bus.mem_wr_data = bus.pe_p;  // PE result is valid in the write cycle itself
  assign bus.pe_a        = pe_a_q;
  assign bus.pe_b        = pe_b_q;
  assign bus.pe_tf       = pe_tf_q;
  assign bus.pe_sub      = pe_sub_q;
  assign bus.pe_inv      = pe_inv_q;

endmodule
